// File: rtl/qracc_pkg.sv
// Shared types and default timing for the QRAcc SRAM controller.
package qracc_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACCESS    = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam int unsigned DEF_NUM_ROWS     = 128;
    localparam int unsigned DEF_NUM_COLS     = 32;
    localparam int unsigned DEF_NUM_CHANNELS = 2;
    localparam int unsigned DEF_PCH_CYCLES   = 1;
    localparam int unsigned DEF_ACC_CYCLES   = 1;

    // Array-facing control bundle for the default geometry.
    typedef struct packed {
        logic [DEF_NUM_ROWS-1:0] wl;
        logic                    pch;
        logic                    write;
        logic                    saen;
        logic [DEF_NUM_COLS-1:0] wr_data;
        logic [DEF_NUM_COLS-1:0] csel;
    } to_sram_t;

    // Array-to-controller bundle for the default geometry.
    typedef struct packed {
        logic [DEF_NUM_COLS-1:0] sa_out;
    } from_sram_t;

endpackage

// File: rtl/qracc_sram_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted channel.
module rr_arbiter #(
    parameter  int unsigned numChannels = 2,
    localparam int unsigned CHW         = (numChannels > 1) ? $clog2(numChannels) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [numChannels-1:0] req,
    input  logic                   update,
    output logic [numChannels-1:0] grant_c,
    output logic [CHW-1:0]         grant_idx_c
);

    logic [CHW-1:0] last_q;
    logic [CHW-1:0] idx;
    logic           found;

    // Last-granted pointer; resets so that channel 0 wins first.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_q <= CHW'(numChannels - 1);
        end else if (update) begin
            last_q <= grant_idx_c;
        end
    end

    // First requesting channel at or after last_q + 1, modulo numChannels.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned off = 1; off <= numChannels; off++) begin
            idx = CHW'((32'(last_q) + off) % numChannels);
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
        end
    end

endmodule

// File: rtl/qracc_sram_ctrl.sv
// Multi-channel SRAM access controller: arbitrates requests and sequences precharge/access.
module qracc_sram_ctrl
    import qracc_pkg::*;
#(
    parameter  int unsigned numRows     = DEF_NUM_ROWS,
    parameter  int unsigned numCols     = DEF_NUM_COLS,
    parameter  int unsigned numChannels = DEF_NUM_CHANNELS,
    parameter  int unsigned pchCycles   = DEF_PCH_CYCLES,
    parameter  int unsigned accCycles   = DEF_ACC_CYCLES,
    localparam int unsigned AW          = (numRows > 1) ? $clog2(numRows) : 1
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [numChannels-1:0]         rq_valid_i,
    input  logic [numChannels-1:0]         rq_wr_i,
    input  logic [numChannels*AW-1:0]      addr_i,
    input  logic [numChannels*numCols-1:0] wr_data_i,
    input  logic [numChannels*numCols-1:0] wr_mask_i,
    output logic [numChannels-1:0]         rq_ready_o,
    output logic [numChannels-1:0]         rd_valid_o,
    output logic [numCols-1:0]             rd_data_o,
    output logic                           busy_o,
    output logic [numRows-1:0]             WL,
    output logic                           PCH,
    output logic                           WRITE,
    output logic                           SAEN,
    output logic [numCols-1:0]             WR_DATA,
    output logic [numCols-1:0]             CSEL,
    input  logic [numCols-1:0]             SA_OUT
);

    localparam int unsigned CHW  = (numChannels > 1) ? $clog2(numChannels) : 1;
    localparam int unsigned MAXC = (pchCycles > accCycles) ? pchCycles : accCycles;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     wr_q;
    logic [AW-1:0]            addr_q;
    logic [numCols-1:0]       data_q, mask_q;
    logic [CHW-1:0]           ch_q;

    logic [numChannels-1:0]   grant_c;
    logic [CHW-1:0]           grant_idx_c;
    logic                     accept_c;
    logic                     addr_ok_c;
    logic                     capture_c;

    logic [numRows-1:0]       wl_d;
    logic                     pch_d, write_d, saen_d;
    logic [numCols-1:0]       wr_data_d, csel_d;
    logic [numChannels-1:0]   rd_valid_d;

    rr_arbiter #(.numChannels(numChannels)) u_arb (
        .clk         (clk),
        .nrst        (nrst),
        .req         (rq_valid_i),
        .update      (accept_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    // Ready only in IDLE (and out of reset); accept when the winner is valid.
    always_comb begin
        rq_ready_o = (state_q == IDLE && nrst) ? grant_c : '0;
        accept_c   = |(rq_valid_i & rq_ready_o);
        addr_ok_c  = 32'(addr_q) < 32'(numRows);
    end

    // Next state, phase counter and next values of the registered array controls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_c  = 1'b0;
        wl_d       = '0;
        pch_d      = 1'b0;
        write_d    = 1'b0;
        saen_d     = 1'b0;
        wr_data_d  = '0;
        csel_d     = '0;
        rd_valid_d = '0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = PRECHARGE;
                    cnt_d   = '0;
                end
            end
            PRECHARGE: begin
                if (cnt_q == CW'(pchCycles - 1)) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACCESS: begin
                if (cnt_q == CW'(accCycles - 1)) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    capture_c = !wr_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            PRECHARGE: pch_d = 1'b1;
            ACCESS: begin
                for (int unsigned i = 0; i < numRows; i++) begin
                    wl_d[i] = (32'(addr_q) == i);
                end
                if (wr_q) begin
                    write_d   = 1'b1;
                    wr_data_d = data_q;
                    csel_d    = mask_q;
                end else begin
                    saen_d = 1'b1;
                    csel_d = '1;
                end
            end
            DONE: begin
                if (!wr_q) begin
                    rd_valid_d[ch_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State, captured request payload and all registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            ch_q       <= '0;
            WL         <= '0;
            PCH        <= 1'b0;
            WRITE      <= 1'b0;
            SAEN       <= 1'b0;
            WR_DATA    <= '0;
            CSEL       <= '0;
            rd_valid_o <= '0;
            rd_data_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            WL         <= wl_d;
            PCH        <= pch_d;
            WRITE      <= write_d;
            SAEN       <= saen_d;
            WR_DATA    <= wr_data_d;
            CSEL       <= csel_d;
            rd_valid_o <= rd_valid_d;
            busy_o     <= (state_d != IDLE);
            if (accept_c) begin
                wr_q   <= rq_wr_i[grant_idx_c];
                addr_q <= addr_i[32'(grant_idx_c)*AW +: AW];
                data_q <= wr_data_i[32'(grant_idx_c)*numCols +: numCols];
                mask_q <= wr_mask_i[32'(grant_idx_c)*numCols +: numCols];
                ch_q   <= grant_idx_c;
            end
            if (capture_c) begin
                rd_data_o <= addr_ok_c ? SA_OUT : '0;
            end
        end
    end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Directed bench for qracc_sram_ctrl with a read-data scoreboard.
module tb_qracc_sram_ctrl;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // Default-configuration instance.
    logic [1:0]   a_valid, a_wr, a_ready, a_rd_valid;
    logic [13:0]  a_addr;
    logic [63:0]  a_wdata, a_mask;
    logic [31:0]  a_rd_data, a_wr_data, a_csel, a_sa;
    logic         a_busy, a_pch, a_write, a_saen;
    logic [127:0] a_wl;

    // Small array, long phases.
    logic [1:0]   b_valid, b_wr, b_ready, b_rd_valid;
    logic [13:0]  b_addr;
    logic [63:0]  b_wdata, b_mask;
    logic [31:0]  b_rd_data, b_wr_data, b_csel, b_sa;
    logic         b_busy, b_pch, b_write, b_saen;
    logic [99:0]  b_wl;

    qracc_sram_ctrl dut_a (
        .clk(clk), .nrst(nrst), .rq_valid_i(a_valid), .rq_wr_i(a_wr), .addr_i(a_addr),
        .wr_data_i(a_wdata), .wr_mask_i(a_mask), .rq_ready_o(a_ready), .rd_valid_o(a_rd_valid),
        .rd_data_o(a_rd_data), .busy_o(a_busy), .WL(a_wl), .PCH(a_pch), .WRITE(a_write),
        .SAEN(a_saen), .WR_DATA(a_wr_data), .CSEL(a_csel), .SA_OUT(a_sa)
    );

    qracc_sram_ctrl #(.numRows(100), .pchCycles(3), .accCycles(2)) dut_b (
        .clk(clk), .nrst(nrst), .rq_valid_i(b_valid), .rq_wr_i(b_wr), .addr_i(b_addr),
        .wr_data_i(b_wdata), .wr_mask_i(b_mask), .rq_ready_o(b_ready), .rd_valid_o(b_rd_valid),
        .rd_data_o(b_rd_data), .busy_o(b_busy), .WL(b_wl), .PCH(b_pch), .WRITE(b_write),
        .SAEN(b_saen), .WR_DATA(b_wr_data), .CSEL(b_csel), .SA_OUT(b_sa)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_cmp    = 0;
    int        n_err    = 0;
    int        n_pulses = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req_a(input int ch, input logic wr, input logic [6:0] addr,
                             input logic [31:0] data, input logic [31:0] mask);
        a_wr[ch]            = wr;
        a_addr[ch*7 +: 7]   = addr;
        a_wdata[ch*32 +: 32] = data;
        a_mask[ch*32 +: 32]  = mask;
    endtask

    // Every read-data pulse from dut_a is matched against the oldest expected read.
    always @(negedge clk) begin
        sb_entry_t e;
        if (nrst && a_rd_valid != 2'b00) begin
            n_pulses++;
            if (sb_q.size() == 0) begin
                chk("rd_unexpected", 128'(a_rd_valid), 128'(0));
            end else begin
                e = sb_q.pop_front();
                chk("rd_chan", 128'(a_rd_valid), 128'(e.ch));
                chk("rd_data", 128'(a_rd_data), 128'(e.data));
            end
        end
    end

    initial begin
        logic [1:0] exp_g;
        nrst    = 1'b0;
        a_valid = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_mask = '0; a_sa = '0;
        b_valid = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_mask = '0; b_sa = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        a_valid = 2'b11;
        #1;
        chk("rst_ready", 128'(a_ready), 128'(0));
        chk("rst_busy", 128'(a_busy), 128'(0));
        chk("rst_rd_valid", 128'(a_rd_valid), 128'(0));
        chk("rst_rd_data", 128'(a_rd_data), 128'(0));
        chk("rst_wl", a_wl, 128'(0));
        chk("rst_pch", 128'(a_pch), 128'(0));
        a_valid = 2'b00;
        nrst = 1'b1;
        tick();

        // Single read, ch0 addr 5
        set_req_a(0, 1'b0, 7'd5, 32'h0, 32'h0);
        a_sa    = 32'hDEADBEEF;
        a_valid = 2'b01;
        #1;
        chk("rd_ready", 128'(a_ready), 128'(2'b01));
        sb_q.push_back('{ch: 2'b01, data: 32'hDEADBEEF});
        tick();
        a_valid = 2'b00;
        chk("rd_pch", 128'(a_pch), 128'(1));
        chk("rd_pch_wl", a_wl, 128'(0));
        chk("rd_pch_saen", 128'(a_saen), 128'(0));
        chk("rd_busy", 128'(a_busy), 128'(1));
        tick();
        chk("rd_wl", a_wl, 128'b1 << 5);
        chk("rd_saen", 128'(a_saen), 128'(1));
        chk("rd_csel", 128'(a_csel), 128'(32'hFFFFFFFF));
        chk("rd_acc_pch", 128'(a_pch), 128'(0));
        tick();
        chk("rd_done_valid", 128'(a_rd_valid), 128'(2'b01));
        chk("rd_done_wl", a_wl, 128'(0));
        tick();
        chk("rd_idle_valid", 128'(a_rd_valid), 128'(0));
        chk("rd_idle_busy", 128'(a_busy), 128'(0));

        // Write, ch1 addr 127
        set_req_a(1, 1'b1, 7'd127, 32'hA5A5A5A5, 32'h0000FFFF);
        a_valid = 2'b10;
        #1;
        chk("wr_ready", 128'(a_ready), 128'(2'b10));
        tick();
        a_valid = 2'b00;
        chk("wr_pch", 128'(a_pch), 128'(1));
        tick();
        chk("wr_wl", a_wl, 128'b1 << 127);
        chk("wr_write", 128'(a_write), 128'(1));
        chk("wr_data", 128'(a_wr_data), 128'(32'hA5A5A5A5));
        chk("wr_csel", 128'(a_csel), 128'(32'h0000FFFF));
        chk("wr_saen", 128'(a_saen), 128'(0));
        tick();
        chk("wr_done_valid", 128'(a_rd_valid), 128'(0));
        chk("wr_done_write", 128'(a_write), 128'(0));
        tick();
        chk("wr_rd_data_hold", 128'(a_rd_data), 128'(32'hDEADBEEF));

        // All-zero mask write, ch0 addr 7
        set_req_a(0, 1'b1, 7'd7, 32'h12345678, 32'h0);
        a_valid = 2'b01;
        tick();
        a_valid = 2'b00;
        tick();
        chk("zm_write", 128'(a_write), 128'(1));
        chk("zm_csel", 128'(a_csel), 128'(0));
        chk("zm_wl", a_wl, 128'b1 << 7);
        tick();
        tick();

        // Reset during the access phase of a read
        set_req_a(1, 1'b0, 7'd3, 32'h0, 32'h0);
        a_valid = 2'b10;
        tick();
        a_valid = 2'b00;
        tick();
        chk("mr_saen_pre", 128'(a_saen), 128'(1));
        #2;
        nrst = 1'b0;
        #1;
        chk("mr_saen", 128'(a_saen), 128'(0));
        chk("mr_wl", a_wl, 128'(0));
        chk("mr_csel", 128'(a_csel), 128'(0));
        chk("mr_busy", 128'(a_busy), 128'(0));
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (4) tick();
        chk("mr_idle_busy", 128'(a_busy), 128'(0));

        // Both channels valid: alternating grants starting at ch0
        set_req_a(0, 1'b0, 7'd1, 32'h0, 32'h0);
        set_req_a(1, 1'b0, 7'd2, 32'h0, 32'h0);
        a_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            a_sa = 32'h1000_0000 + 32'(i);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_grant", 128'(a_ready), 128'(exp_g));
            sb_q.push_back('{ch: exp_g, data: a_sa});
            tick();
            chk("rr_busy_ready", 128'(a_ready), 128'(0));
            tick();
            tick();
            tick();
        end
        a_valid = 2'b00;
        repeat (2) tick();

        // numRows=100, pch=3, acc=2: out-of-range read addr 110
        b_addr[6:0] = 7'd110;
        b_sa        = 32'hFFFFFFFF;
        b_valid     = 2'b01;
        #1;
        chk("b_ready", 128'(b_ready), 128'(2'b01));
        tick();
        b_valid = 2'b00;
        for (int c = 1; c <= 7; c++) begin
            chk("b_pch", 128'(b_pch), 128'(c >= 1 && c <= 3));
            chk("b_saen", 128'(b_saen), 128'(c == 4 || c == 5));
            chk("b_rd_valid", 128'(b_rd_valid), 128'((c == 6) ? 2'b01 : 2'b00));
            chk("b_wl", 128'(b_wl), 128'(0));
            if (c == 6) chk("b_rd_data", 128'(b_rd_data), 128'(0));
            tick();
        end

        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        chk("rd_pulses", 128'(n_pulses), 128'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
